// File: rtl/onehot_codec_pkg.sv
// Shared constants and encode helpers for the one-hot codec.
package onehot_codec_pkg;

  localparam int unsigned DefaultN = 8;
  localparam int unsigned DefaultW = $clog2(DefaultN);

  // Index of the highest set bit; 0 for an all-zero vector.
  function automatic logic [DefaultW-1:0] f_prio_enc(input logic [DefaultN-1:0] v);
    logic [DefaultW-1:0] idx;
    idx = '0;
    for (int unsigned i = 0; i < DefaultN; i++) begin
      if (v[i]) idx = DefaultW'(i);
    end
    return idx;
  endfunction

  function automatic logic f_popcnt_ge2(input logic [DefaultN-1:0] v);
    logic seen;
    logic ge2;
    seen = 1'b0;
    ge2  = 1'b0;
    for (int unsigned i = 0; i < DefaultN; i++) begin
      if (v[i]) begin
        ge2  = ge2 | seen;
        seen = 1'b1;
      end
    end
    return ge2;
  endfunction

endpackage

// File: rtl/onehot_decoder.sv
// Binary-to-one-hot decoder with enable; output is all-zero when disabled.
module onehot_decoder #(
  parameter int unsigned N = 8,
  parameter int unsigned W = $clog2(N)
) (
  input  logic [W-1:0] Y,
  input  logic         en,
  output logic [N-1:0] OD
);

  always_comb begin
    OD = '0;
    if (en) OD[Y] = 1'b1;
  end

endmodule

// File: rtl/onehot_codec.sv
// Registered priority encoder chained to a one-hot decoder.
// Optional self-check enabled by defining ONEHOT_CODEC_CHECK_EN.
module onehot_codec
  import onehot_codec_pkg::*;
#(
  parameter int unsigned N = DefaultN,
  parameter int unsigned W = DefaultW
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] I,
  output logic [W-1:0] Y,
  output logic         valid,
  output logic         multi,
  output logic [N-1:0] OD
`ifdef ONEHOT_CODEC_CHECK_EN
  ,
  output logic         mismatch
`endif
);

  logic [W-1:0] y_q;
  logic         valid_q;
  logic         multi_q;

  // Zero input naturally yields index 0 with valid and multi clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      y_q     <= '0;
      valid_q <= 1'b0;
      multi_q <= 1'b0;
    end else begin
      y_q     <= f_prio_enc(I);
      valid_q <= |I;
      multi_q <= f_popcnt_ge2(I);
    end
  end

  assign Y     = y_q;
  assign valid = valid_q;
  assign multi = multi_q;

  onehot_decoder #(
    .N(N),
    .W(W)
  ) u_decoder (
    .Y (y_q),
    .en(valid_q),
    .OD(OD)
  );

`ifdef ONEHOT_CODEC_CHECK_EN
  logic [N-1:0] i_q;
  logic         mismatch_q;

  // i_q aligns with OD: both reflect the input captured at the previous edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      i_q        <= '0;
      mismatch_q <= 1'b0;
    end else begin
      i_q        <= I;
      mismatch_q <= valid_q && !multi_q && (OD != i_q);
    end
  end

  assign mismatch = mismatch_q;

  always_ff @(posedge clk) begin
    if (!rst) assert ($onehot0(OD));
  end
`else
  // Checker state is absent in this build.
`endif

endmodule

// File: tb/tb_onehot_codec.sv
// Randomized and directed self-checking bench for onehot_codec.
module tb_onehot_codec;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] I   = 8'hFF;
  logic [2:0] Y;
  logic       valid;
  logic       multi;
  logic [7:0] OD;
`ifdef ONEHOT_CODEC_CHECK_EN
  logic       mismatch;
`endif

  int errors = 0;
  int checks = 0;

  // Reference state: what the outputs should show after the latest edge.
  logic [2:0] m_y     = 3'd0;
  logic       m_valid = 1'b0;
  logic       m_multi = 1'b0;

  onehot_codec u_dut (
    .clk  (clk),
    .rst  (rst),
    .I    (I),
    .Y    (Y),
    .valid(valid),
    .multi(multi),
    .OD   (OD)
`ifdef ONEHOT_CODEC_CHECK_EN
    ,
    .mismatch(mismatch)
`endif
  );

  always #5 clk = ~clk;

  // Highest set bit by arithmetic: floor(log2(v)).
  function automatic logic [2:0] hi_bit(input logic [7:0] v);
    int unsigned x;
    x = v;
    if (v == 8'h00) return 3'd0;
    return 3'($clog2(x + 1) - 1);
  endfunction

  function automatic logic [7:0] ref_od();
    logic [7:0] one;
    one = 8'h01;
    return m_valid ? (one << m_y) : 8'h00;
  endfunction

  // Apply one input, take an edge, advance the model, settle past the edge.
  task automatic step(input logic [7:0] in, input logic r);
    I   = in;
    rst = r;
    @(posedge clk);
    if (r) begin
      m_y = 3'd0; m_valid = 1'b0; m_multi = 1'b0;
    end else begin
      m_y     = hi_bit(in);
      m_valid = (in != 8'h00);
      m_multi = ($countones(in) >= 2);
    end
    #1;
  endtask

  task automatic test_reset();
    for (int c = 0; c < 2; c++) begin
      step(8'hFF, 1'b1);
      checks++;
      if ({Y, valid, multi, OD} !== {3'd0, 1'b0, 1'b0, 8'h00}) begin
        errors++;
        $display("FAIL reset[%0d]: got Y=%0d valid=%0b multi=%0b OD=%02h, want 0/0/0/00",
                 c, Y, valid, multi, OD);
      end
    end
  endtask

  task automatic test_onehot_sweep();
    logic [7:0] one;
    logic [7:0] v;
    one = 8'h01;
    for (int k = 0; k < 8; k++) begin
      v = one << k;
      step(v, 1'b0);
      checks++;
      if ({Y, valid, multi, OD} !== {3'(k), 1'b1, 1'b0, v}) begin
        errors++;
        $display("FAIL sweep k=%0d: got Y=%0d valid=%0b multi=%0b OD=%02h, want %0d/1/0/%02h",
                 k, Y, valid, multi, OD, k, v);
      end
`ifdef ONEHOT_CODEC_CHECK_EN
      checks++;
      if (mismatch !== 1'b0) begin
        errors++;
        $display("FAIL sweep_mismatch k=%0d: got %0b want 0", k, mismatch);
      end
`endif
    end
  endtask

  task automatic test_zero();
    step(8'h00, 1'b0);
    checks++;
    if ({Y, valid, multi, OD} !== {3'd0, 1'b0, 1'b0, 8'h00}) begin
      errors++;
      $display("FAIL zero: got Y=%0d valid=%0b multi=%0b OD=%02h, want 0/0/0/00",
               Y, valid, multi, OD);
    end
  endtask

  task automatic test_priority();
    step(8'b1000_0001, 1'b0);
    checks++;
    if ({Y, valid, multi, OD} !== {3'd7, 1'b1, 1'b1, 8'h80}) begin
      errors++;
      $display("FAIL prio_81: got Y=%0d valid=%0b multi=%0b OD=%02h, want 7/1/1/80",
               Y, valid, multi, OD);
    end
    step(8'b0000_0110, 1'b0);
    checks++;
    if ({Y, valid, multi, OD} !== {3'd2, 1'b1, 1'b1, 8'h04}) begin
      errors++;
      $display("FAIL prio_06: got Y=%0d valid=%0b multi=%0b OD=%02h, want 2/1/1/04",
               Y, valid, multi, OD);
    end
    step(8'h03, 1'b0);
    step(8'h03, 1'b0);
`ifdef ONEHOT_CODEC_CHECK_EN
    checks++;
    if (mismatch !== 1'b0) begin
      errors++;
      $display("FAIL multi_mismatch: got %0b want 0", mismatch);
    end
`endif
    checks++;
    if ({Y, multi, OD} !== {3'd1, 1'b1, 8'h02}) begin
      errors++;
      $display("FAIL prio_03: got Y=%0d multi=%0b OD=%02h, want 1/1/02", Y, multi, OD);
    end
  endtask

  task automatic test_reset_midstream();
    step(8'h10, 1'b0);
    checks++;
    if ({Y, valid, OD} !== {3'd4, 1'b1, 8'h10}) begin
      errors++;
      $display("FAIL mid_capture: got Y=%0d valid=%0b OD=%02h, want 4/1/10", Y, valid, OD);
    end
    step(8'h40, 1'b1);
    checks++;
    if ({Y, valid, multi, OD} !== {3'd0, 1'b0, 1'b0, 8'h00}) begin
      errors++;
      $display("FAIL mid_reset: got Y=%0d valid=%0b multi=%0b OD=%02h, want 0/0/0/00",
               Y, valid, multi, OD);
    end
    step(8'h02, 1'b0);
    checks++;
    if ({Y, valid, OD} !== {3'd1, 1'b1, 8'h02}) begin
      errors++;
      $display("FAIL mid_resume: got Y=%0d valid=%0b OD=%02h, want 1/1/02", Y, valid, OD);
    end
  endtask

  task automatic test_random();
    logic [7:0] v;
    logic [7:0] one;
    logic       r;
    one = 8'h01;
    for (int n = 0; n < 300; n++) begin
      case ($urandom_range(0, 3))
        0:       v = 8'h00;
        1:       v = one << $urandom_range(0, 7);
        2:       v = (one << $urandom_range(0, 7)) | (one << $urandom_range(0, 7));
        default: v = 8'($urandom);
      endcase
      r = ($urandom_range(0, 19) == 0);
      step(v, r);
      checks++;
      if ({Y, valid, multi, OD} !== {m_y, m_valid, m_multi, ref_od()}) begin
        errors++;
        $display("FAIL random[%0d] I=%02h rst=%0b: got Y=%0d valid=%0b multi=%0b OD=%02h, want %0d/%0b/%0b/%02h",
                 n, v, r, Y, valid, multi, OD, m_y, m_valid, m_multi, ref_od());
      end
    end
  endtask

  initial begin
    test_reset();
    test_onehot_sweep();
    test_zero();
    test_priority();
    test_reset_midstream();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/onehot_codec.md
Name: onehot_codec

Overview:
- Registered 8-to-3 priority encoder (binary code, valid flag and multi-hot flag) chained to a 3-to-8 one-hot decoder.
- The decoder output reconstructs the one-hot input from the encoded value.
- Sits between one-hot request/select sources and binary-indexed consumers; also serves as a round-trip sanity block.

Parameters:
- N, 8, one-hot input width; must be a power of two, at least 2.
- W, $clog2(N) = 3, encoded output width.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- I  in  N  one-hot (ideally) input vector.
- Y  out  W  registered binary index of the highest set bit of I.
- valid  out  1  registered; 1 when the captured I had at least one bit set.
- multi  out  1  registered; 1 when the captured I had two or more bits set.
- OD  out  N  decoded one-hot vector from registered Y, gated by valid.

Behaviour:
- Reset: when rst=1 at a rising edge, Y<=0, valid<=0 and multi<=0; OD therefore reads 0. Reset has priority over capture.
- Encode:
  - Each rising edge with rst=0 captures I.
  - Y = index of the highest-numbered set bit (bit N-1 has highest priority).
  - valid = |I.
  - multi = 1 when popcount(I) >= 2.
- Latency: exactly 1 cycle from I to Y, valid and multi. No handshake; a new input is accepted every cycle.
- Zero input: Y<=0, valid<=0, multi<=0.
- Decode:
  - OD is combinational from the registered Y and valid, so it updates in the same cycle as Y.
  - OD = (1 << Y) when valid=1; OD = 0 when valid=0.
  - Exactly one bit of OD is set whenever valid=1.
- Round trip: for a one-hot I, OD one cycle later equals I.
- For a multi-hot I, OD holds only the highest set bit of I.
- Reset mid-stream: the in-flight value is discarded; the first post-reset capture occurs on the first edge with rst=0.
- No X propagation: all outputs are defined from reset onward.

Optional Feature:
- Macro: ONEHOT_CODEC_CHECK_EN.
- When defined:
  - Adds output port mismatch (1 bit, registered).
  - The block also registers I as I_q.
  - Each cycle, mismatch <= (valid && !multi && OD != I_q); reset value 0.
  - Adds an assertion that OD is one-hot or zero.
- When not defined: no mismatch port, no I_q register, no assertion. Encode/decode behaviour is identical in both builds.

Decomposition:
- Package onehot_codec_pkg holds:
  - the N and W defaults as constants;
  - a function f_prio_enc(N-bit) returning a W-bit index;
  - a function f_popcnt_ge2 for the multi flag.
- One sub-module, onehot_decoder (inputs Y and en, output OD), instantiated once. It is reusable stand-alone as a 3-to-8 decoder with enable.

Test Plan:
- Reset: hold rst=1 for 2 cycles with I=8'hFF -> Y=0, valid=0, multi=0, OD=8'h00.
- One-hot sweep: I = 1<<k for k=0..7 on consecutive cycles -> one cycle later Y=k, valid=1, multi=0, OD = 1<<k (e.g. I=8'b0010_0000 -> Y=3'b101, OD=8'b0010_0000).
- Zero input: I=8'h00 -> Y=0, valid=0, multi=0, OD=8'h00.
- Priority: I=8'b1000_0001 -> Y=7, multi=1, OD=8'h80; I=8'b0000_0110 -> Y=2, multi=1, OD=8'h04.
- Reset mid-stream: I=8'h10 captured, then rst=1 for one edge -> Y=0, valid=0; next edge with rst=0 and I=8'h02 -> Y=1, OD=8'h02.
- With ONEHOT_CODEC_CHECK_EN: the one-hot sweep keeps mismatch=0 throughout; I=8'h03 also keeps mismatch=0, because multi=1 suppresses the check.
